// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and memory port signals for mem_arbiter.
// slave modport faces the arbiter; master faces core and memory.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    i_read;
    logic [ADDR_WIDTH-1:0]   i_addr;
    logic [DATA_WIDTH-1:0]   i_rdata;
    logic                    i_resp;
    logic                    d_read;
    logic                    d_write;
    logic [ADDR_WIDTH-1:0]   d_addr;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic [DATA_WIDTH/8-1:0] d_wmask;
    logic [DATA_WIDTH-1:0]   d_rdata;
    logic                    d_resp;
    logic                    mem_read;
    logic                    mem_write;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_wmask;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_resp;

    modport slave (
        input  i_read, i_addr,
        input  d_read, d_write, d_addr, d_wdata, d_wmask,
        input  mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output mem_read, mem_write, mem_addr,
        output mem_wdata, mem_wmask
    );

    modport master (
        output i_read, i_addr,
        output d_read, d_write, d_addr, d_wdata, d_wmask,
        output mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  mem_read, mem_write, mem_addr,
        input  mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch vs load/store arbiter for the single memory port, one txn at a time.
// Define MEM_ARB_RR_EN for round-robin ties; default gives data priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;

    logic [1:0] state;
    logic       i_req;
    logic       d_req;
    logic       pick_d;

`ifdef MEM_ARB_RR_EN
    logic       last_grant;
`endif

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

`ifdef MEM_ARB_RR_EN
    // Tie goes to whoever was not granted last (0=I, 1=D)
    assign pick_d = d_req & (~i_req | ~last_grant);
`else
    assign pick_d = d_req;
`endif

    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
    assign bus.i_resp  = (state == GRANT_I) & bus.mem_resp;
    assign bus.d_resp  = (state == GRANT_D) & bus.mem_resp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wmask <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state         <= GRANT_D;
                        bus.mem_addr  <= bus.d_addr;
                        bus.mem_wdata <= bus.d_wdata;
                        bus.mem_wmask <= bus.d_wmask;
                        // Illegal read+write: write wins
                        bus.mem_write <= bus.d_write;
                        bus.mem_read  <= ~bus.d_write;
`ifdef MEM_ARB_RR_EN
                        last_grant    <= 1'b1;
`endif
                    end else if (i_req) begin
                        state         <= GRANT_I;
                        bus.mem_addr  <= bus.i_addr;
                        bus.mem_wdata <= '0;
                        bus.mem_wmask <= '0;
                        bus.mem_write <= 1'b0;
                        bus.mem_read  <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_grant    <= 1'b0;
`endif
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (bus.mem_resp) begin
                        state         <= IDLE;
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        bus.mem_wmask <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
